dispatch: RTL and testbench

Front end of the dual-issue pipeline that feeds `issue_queue` on its push side.
- Accepts up to two fetched instructions per cycle from the fetch stage.
- Holds them in a two-entry in-order pending buffer and decodes them into `ISSUE_QUEUE_ELEMENT`.
- Pushes them to the issue queue, never more than `size_left` allows.
- It is the producer end of the interface whose consumer end is `issue` (`out_data`/`out_data_number`).

---
 rtl/dispatch_pkg.sv | 24 ++
 rtl/dispatch_inst_decode.sv | 58 +++++
 rtl/dispatch.sv | 67 ++++++
 tb/tb_dispatch.sv | 123 ++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared issue-queue element type, address widths and MIPS opcode constants
package dispatch_pkg;
  typedef logic bool;
  typedef logic [4:0] IQ_ADDR;
  typedef logic [4:0] REG_ADDR;
  typedef enum logic [2:0] {OP_ALU, OP_ALU_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JUMP, OP_NONE} op_class_e;
  typedef struct packed {
    bool         reserved_inst;
    op_class_e   op_class;
    REG_ADDR     rs;
    REG_ADDR     rt;
    REG_ADDR     rd;
    bool         dst_we;
    logic [31:0] imm;
    logic [31:0] pc;
  } ISSUE_QUEUE_ELEMENT;
  localparam logic [5:0] OPC_SPECIAL = 6'h00, OPC_REGIMM = 6'h01, OPC_J = 6'h02, OPC_JAL = 6'h03;
  localparam logic [5:0] OPC_BEQ = 6'h04, OPC_BNE = 6'h05, OPC_BLEZ = 6'h06, OPC_BGTZ = 6'h07;
  localparam logic [5:0] OPC_ADDI = 6'h08, OPC_ADDIU = 6'h09, OPC_SLTI = 6'h0a, OPC_SLTIU = 6'h0b;
  localparam logic [5:0] OPC_ANDI = 6'h0c, OPC_ORI = 6'h0d, OPC_XORI = 6'h0e, OPC_LUI = 6'h0f;
  localparam logic [5:0] OPC_LB = 6'h20, OPC_LH = 6'h21, OPC_LW = 6'h23, OPC_LBU = 6'h24, OPC_LHU = 6'h25;
  localparam logic [5:0] OPC_SB = 6'h28, OPC_SH = 6'h29, OPC_SW = 6'h2b;
  localparam logic [5:0] FN_JR = 6'h08, FN_JALR = 6'h09;
endpackage

// File: rtl/dispatch_inst_decode.sv
// inst_decode: combinational MIPS instruction word to issue-queue element decoder
module inst_decode
  import dispatch_pkg::*;
(
  input  logic [31:0]        inst,
  input  logic [31:0]        pc,
  output ISSUE_QUEUE_ELEMENT e
);
  logic [5:0] opc, fn;
  logic [31:0] sext, zext;
  assign opc  = inst[31:26];
  assign fn   = inst[5:0];
  assign sext = {{16{inst[15]}}, inst[15:0]};
  assign zext = {16'd0, inst[15:0]};
  // I-type ALU with sign-extended immediate writing rt is the default shape; other classes override it
  always_comb begin
    e = '0;
    e.pc = pc;
    e.rs = inst[25:21];
    e.rt = inst[20:16];
    e.rd = inst[20:16];
    e.imm = sext;
    e.dst_we = 1'b1;
    e.op_class = OP_ALU_IMM;
    case (opc)
      OPC_SPECIAL: begin
        e.op_class = (fn == FN_JR || fn == FN_JALR) ? OP_JUMP : OP_ALU;
        e.rd = inst[15:11];
        e.dst_we = fn != FN_JR;
        e.imm = {27'd0, inst[10:6]};
      end
      OPC_ADDI, OPC_ADDIU, OPC_SLTI, OPC_SLTIU: e.op_class = OP_ALU_IMM;
      OPC_ANDI, OPC_ORI, OPC_XORI: e.imm = zext;
      OPC_LUI: e.imm = {inst[15:0], 16'd0};
      OPC_LB, OPC_LH, OPC_LW, OPC_LBU, OPC_LHU: e.op_class = OP_LOAD;
      OPC_SB, OPC_SH, OPC_SW: begin
        e.op_class = OP_STORE;
        e.dst_we = 1'b0;
      end
      OPC_REGIMM, OPC_BEQ, OPC_BNE, OPC_BLEZ, OPC_BGTZ: begin
        e.op_class = OP_BRANCH;
        e.dst_we = 1'b0;
      end
      OPC_J, OPC_JAL: begin
        e.op_class = OP_JUMP;
        e.imm = {6'd0, inst[25:0]};
        e.rd = 5'd31;
        e.dst_we = opc == OPC_JAL;
      end
      default: begin
        e.reserved_inst = 1'b1;
        e.op_class = OP_NONE;
        e.dst_we = 1'b0;
      end
    endcase
    e.dst_we = e.dst_we && e.rd != 5'd0;
  end
endmodule

// File: rtl/dispatch.sv
// dispatch: two-entry in-order pending buffer feeding the issue queue (perf counters under DISPATCH_PERF_CNT_EN)
module dispatch
  import dispatch_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [1:0]               fetch_valid,
  input  logic [1:0][31:0]         fetch_inst,
  input  logic [1:0][31:0]         fetch_pc,
  output logic                     fetch_ready,
  input  IQ_ADDR                   size_left,
  output ISSUE_QUEUE_ELEMENT [1:0] in_data,
`ifdef DISPATCH_PERF_CNT_EN
  output logic [31:0]              perf_dispatched,
  output logic [31:0]              perf_stall_cycles,
`endif
  output logic [1:0]               in_data_number
);
  logic [1:0] pend, push_n, left;
  logic [LANES-1:0][31:0] slot_inst, slot_pc;
  ISSUE_QUEUE_ELEMENT [LANES-1:0] dec;
  logic accept;
  for (genvar i = 0; i < LANES; i++) begin : g_dec
    inst_decode u_dec (.inst(slot_inst[i]), .pc(slot_pc[i]), .e(dec[i]));
  end
  assign push_n = flush ? 2'd0 : ({3'd0, pend} <= size_left ? pend : size_left[1:0]);
  assign left = pend - push_n;
  assign fetch_ready = rst && !flush && left == 2'd0;
  assign accept = fetch_ready && fetch_valid[0];
  assign in_data_number = push_n;
  assign in_data = rst ? dec : '0;
  // buffer: flush discards, accept reloads, a single push from a full buffer compacts slot 1 into slot 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= 2'd0;
      slot_inst <= '0;
      slot_pc <= '0;
    end else if (flush) begin
      pend <= 2'd0;
    end else if (accept) begin
      slot_inst <= fetch_inst;
      slot_pc <= fetch_pc;
      pend <= fetch_valid[1] ? 2'd2 : 2'd1;
    end else begin
      if (pend == 2'd2 && push_n == 2'd1) begin
        slot_inst[0] <= slot_inst[1];
        slot_pc[0] <= slot_pc[1];
      end
      pend <= left;
    end
  end
`ifdef DISPATCH_PERF_CNT_EN
  // pushed-entry total and cycles where pending work was held back by a full queue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_dispatched <= '0;
      perf_stall_cycles <= '0;
    end else begin
      perf_dispatched <= perf_dispatched + {30'd0, push_n};
      if (pend != 2'd0 && push_n < pend && !flush) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dispatch.sv
// tb_dispatch: table-driven directed check of the dispatch buffer, handshake and decode
module tb_dispatch;
  import dispatch_pkg::*;
  localparam logic [31:0] ADDU = 32'h00221821, LW = 32'h8CA40008, RES = 32'hFC000000;
  localparam logic [31:0] ORI = 32'h3401FFFF, ADDIU = 32'h2401FFFF;
  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, fetch_ready;
  logic [1:0] fetch_valid = 2'b00, in_data_number;
  logic [1:0][31:0] fetch_inst = '0, fetch_pc = '0;
  IQ_ADDR size_left = 5'd8;
  ISSUE_QUEUE_ELEMENT [1:0] in_data;
`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] perf_dispatched, perf_stall_cycles, stall_base;
`endif
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic fl;
    logic [1:0] fv;
    logic [31:0] i0, i1, p0, p1;
    logic [4:0] sl;
    logic rdy;
    logic [1:0] num;
    logic [31:0] e0, e1;
    logic res0;
  } vec_t;
  vec_t v[19];
  dispatch u_dut (
    .clk(clk), .rst(rst), .flush(flush), .fetch_valid(fetch_valid), .fetch_inst(fetch_inst),
    .fetch_pc(fetch_pc), .fetch_ready(fetch_ready), .size_left(size_left), .in_data(in_data),
`ifdef DISPATCH_PERF_CNT_EN
    .perf_dispatched(perf_dispatched), .perf_stall_cycles(perf_stall_cycles),
`endif
    .in_data_number(in_data_number)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic fl, input logic [1:0] fv, input logic [31:0] i0, i1, p0, p1, input logic [4:0] sl);
    flush = fl;
    fetch_valid = fv;
    fetch_inst[0] = i0;
    fetch_inst[1] = i1;
    fetch_pc[0] = p0;
    fetch_pc[1] = p1;
    size_left = sl;
  endtask
  initial begin
    v[0]  = '{0, 2'b11, ADDU, LW, 32'h100, 32'h104, 5'd8, 1, 2'd0, 0, 0, 0};
    v[1]  = '{0, 2'b11, ADDU, LW, 32'h108, 32'h10c, 5'd8, 1, 2'd2, 32'h100, 32'h104, 0};
    v[2]  = '{0, 2'b00, 0, 0, 0, 0, 5'd8, 1, 2'd2, 32'h108, 32'h10c, 0};
    v[3]  = '{0, 2'b11, ADDU, LW, 32'h100, 32'h104, 5'd8, 1, 2'd0, 0, 0, 0};
    v[4]  = '{0, 2'b11, ADDU, LW, 32'h108, 32'h10c, 5'd1, 0, 2'd1, 32'h100, 0, 0};
    v[5]  = '{0, 2'b00, 0, 0, 0, 0, 5'd1, 1, 2'd1, 32'h104, 0, 0};
    v[6]  = '{0, 2'b11, ADDU, LW, 32'h100, 32'h104, 5'd8, 1, 2'd0, 0, 0, 0};
    for (int k = 7; k < 12; k++) v[k] = '{0, 2'b11, ADDU, LW, 32'h300, 32'h304, 5'd0, 0, 2'd0, 0, 0, 0};
    v[12] = '{1, 2'b11, ADDU, LW, 32'h300, 32'h304, 5'd0, 0, 2'd0, 0, 0, 0};
    v[13] = '{0, 2'b01, ADDU, LW, 32'h200, 32'h204, 5'd8, 1, 2'd0, 0, 0, 0};
    v[14] = '{0, 2'b00, 0, 0, 0, 0, 5'd8, 1, 2'd1, 32'h200, 0, 0};
    v[15] = '{0, 2'b10, ADDU, LW, 32'h500, 32'h504, 5'd8, 1, 2'd0, 0, 0, 0};
    v[16] = '{0, 2'b00, 0, 0, 0, 0, 5'd8, 1, 2'd0, 0, 0, 0};
    v[17] = '{0, 2'b01, RES, 0, 32'h400, 0, 5'd8, 1, 2'd0, 0, 0, 0};
    v[18] = '{0, 2'b00, 0, 0, 0, 0, 5'd8, 1, 2'd1, 32'h400, 0, 1};
    repeat (3) begin
      @(negedge clk);
      chk("reset ready", {31'd0, fetch_ready}, 0);
      chk("reset num", {30'd0, in_data_number}, 0);
    end
    chk("reset in_data", in_data[0].pc | in_data[1].pc | {31'd0, in_data[0].dst_we}, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("idle ready", {31'd0, fetch_ready}, 1);
    chk("idle num", {30'd0, in_data_number}, 0);
    for (int k = 0; k < 19; k++) begin
      @(posedge clk); #1 drive(v[k].fl, v[k].fv, v[k].i0, v[k].i1, v[k].p0, v[k].p1, v[k].sl);
      @(negedge clk);
      chk($sformatf("v%0d ready", k), {31'd0, fetch_ready}, {31'd0, v[k].rdy});
      chk($sformatf("v%0d num", k), {30'd0, in_data_number}, {30'd0, v[k].num});
      if (v[k].num >= 2'd1) begin
        chk($sformatf("v%0d pc0", k), in_data[0].pc, v[k].e0);
        chk($sformatf("v%0d res0", k), {31'd0, in_data[0].reserved_inst}, {31'd0, v[k].res0});
      end
      if (v[k].num == 2'd2) chk($sformatf("v%0d pc1", k), in_data[1].pc, v[k].e1);
`ifdef DISPATCH_PERF_CNT_EN
      if (k == 7) stall_base = perf_stall_cycles;
      if (k == 12) chk("perf stall delta", perf_stall_cycles - stall_base, 32'd5);
`endif
    end
    @(posedge clk); #1 drive(0, 2'b11, ADDU, LW, 32'h600, 32'h604, 5'd8);
    @(posedge clk); #1 drive(0, 2'b11, ORI, ADDIU, 32'h608, 32'h60c, 5'd8);
    @(negedge clk);
    chk("addu class", {29'd0, in_data[0].op_class}, {29'd0, OP_ALU});
    chk("addu rd", {27'd0, in_data[0].rd}, 32'd3);
    chk("addu we", {31'd0, in_data[0].dst_we}, 1);
    chk("lw class", {29'd0, in_data[1].op_class}, {29'd0, OP_LOAD});
    chk("lw rs", {27'd0, in_data[1].rs}, 32'd5);
    chk("lw rd", {27'd0, in_data[1].rd}, 32'd4);
    chk("lw imm", in_data[1].imm, 32'd8);
    @(posedge clk); #1 drive(0, 2'b00, 0, 0, 0, 0, 5'd8);
    @(negedge clk);
    chk("ori imm", in_data[0].imm, 32'h0000FFFF);
    chk("addiu imm", in_data[1].imm, 32'hFFFFFFFF);
    chk("ori pc", in_data[0].pc, 32'h608);
    @(posedge clk); #1 drive(0, 2'b11, ADDU, LW, 32'h700, 32'h704, 5'd8);
    @(posedge clk); #1 drive(0, 2'b00, 0, 0, 0, 0, 5'd0);
    @(negedge clk);
    chk("stall num", {30'd0, in_data_number}, 0);
    #2 rst = 1'b0;
    #1;
    chk("midreset ready", {31'd0, fetch_ready}, 0);
    chk("midreset in_data", in_data[0].pc | in_data[1].pc, 0);
    @(posedge clk); #1 rst = 1'b1;
    size_left = 5'd8;
    @(negedge clk);
    chk("post reset num", {30'd0, in_data_number}, 0);
    chk("post reset ready", {31'd0, fetch_ready}, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
